lsu_ext: RTL
============

Name: lsu_ext

Overview:
Second-generation load/store unit for the single-issue core. Sits between EXU and WBU and drives the data-side memory bus. Supports all RV32I/RV64I load/store widths with sign/zero extension and a parametrised data-bus width. Unlike the first-generation LSU it adds:
- full valid/ready backpressure on both sides;
- a request-accept handshake;
- misalignment and bus-error/timeout exception reporting.

Parameters:
DATA_W, 32, bus and register data width; legal values 32 or 64.
ADDR_W, 32, address width.
TIMEOUT, 255, maximum cycles waiting for lsu_respValid before raising an access fault; 0 disables the timeout.

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-low reset
in_valid  in  1  EXU presents an op
in_ready  out  1  LSU accepts an op
mem_en  in  1  op touches memory; 0 means pass-through
mem_wen  in  1  store (1) / load (0)
funct3  in  3  RISC-V width/sign code
addr  in  ADDR_W  effective byte address
wdata  in  DATA_W  store data, LSB-aligned
out_valid  out  1  result valid to WBU
out_ready  in  1  WBU accepts result
rdata_out  out  DATA_W  extended load data; 0 for stores and pass-through ops
exc_valid  out  1  exception accompanies out_valid
exc_code  out  4  4 = load misaligned, 5 = load fault, 6 = store misaligned, 7 = store fault
lsu_reqValid  out  1  bus request
lsu_reqReady  in  1  bus accepts request
lsu_addr  out  ADDR_W  byte address
lsu_size  out  2  log2 of bytes
lsu_wen  out  1  write
lsu_wdata  out  DATA_W  lane-shifted store data
lsu_wmask  out  DATA_W/8  byte strobes
lsu_respValid  in  1  bus response
lsu_respErr  in  1  bus error, qualified by lsu_respValid
lsu_rdata  in  DATA_W  full-lane read data

Behaviour:
- Reset (reset == 0 at a clock edge):
  - state returns to IDLE; the reset works mid-transaction and any outstanding response is dropped;
  - all outputs are 0 except in_ready = 1;
  - the timeout counter is 0.
- States:
  - IDLE: in_ready = 1. On in_valid, capture all inputs.
    - mem_en = 0 → DONE.
    - Misaligned access (h at addr[0]; w at addr[1:0]; d at addr[2:0]), or d with DATA_W = 32 (that case is a fault) → DONE with exception; no bus request is issued.
    - Otherwise → REQ.
  - REQ: lsu_reqValid = 1, with addr/size/wen/wdata/wmask held stable until lsu_reqReady. lsu_reqValid && lsu_reqReady → WAIT.
  - WAIT: count cycles.
    - lsu_respValid → DONE, with a fault code if lsu_respErr.
    - count reaching TIMEOUT → DONE with a fault code.
  - DONE: out_valid = 1 with rdata_out/exc_* stable until out_ready → IDLE.
- Latency:
  - pass-through: 2 cycles from accept to out_valid;
  - memory op with zero-wait bus: accept → REQ (1) → WAIT (2) → DONE (3).
- Lanes (let off = addr[log2(DATA_W/8)-1:0]):
  - lsu_wdata = wdata << 8·off;
  - lsu_wmask = ((1 << bytes) − 1) << off;
  - lsu_addr = addr (byte address, unaligned low bits retained);
  - lsu_wmask = 0 for loads.
- Load extract: (lsu_rdata >> 8·off), truncated to the access width, then:
  - funct3 000/001/010: sign-extended;
  - funct3 100/101/110: zero-extended;
  - funct3 011: full width.
  - Illegal funct3 (111, or 011/110 with DATA_W = 32) → load-fault exception.
- A response arriving in the same cycle the counter hits TIMEOUT is treated as a response, not a timeout.
- lsu_respValid outside WAIT is ignored.
- exc_valid and exc_code are 0 whenever out_valid is 0.

Decomposition:
- Shared package lsu_pkg:
  - FSM state enum;
  - funct3 constants;
  - exception code constants;
  - helper function giving access bytes from funct3.
- One natural sub-module, lsu_lane_align (purely combinational, parametrised by DATA_W). It produces:
  - wdata shift and wmask;
  - load extraction and extension;
  - misalignment/illegal detection.
- The FSM and timeout counter stay in lsu_ext.

Test Plan:
- sb with addr 0x8000_0003, wdata 0xAB, DATA_W = 32 → lsu_wmask 4'b1000, lsu_wdata 0xAB00_0000, lsu_size 0; out_valid with rdata_out 0.
- lh at addr 0x8000_0002, lsu_rdata 0x8001_1234 → rdata_out 0xFFFF_8001; lhu at the same address → 0x0000_8001.
- lw at addr 0x8000_0006 → no lsu_reqValid ever; out_valid with exc_valid = 1, exc_code 4 two cycles after accept.
- sw with lsu_reqReady held low for 5 cycles → lsu_reqValid and all request fields stable for all 5 cycles; lsu_respValid with lsu_respErr = 1 → exc_code 7.
- lw with TIMEOUT = 8 and no response → out_valid with exc_code 5 at the 8th WAIT cycle; a late lsu_respValid afterwards is ignored and does not affect the next op.
- out_ready held low for 3 cycles after lbu returning 0xFF → rdata_out 0x0000_00FF stable and in_ready = 0 throughout; reset asserted (low) during WAIT → next cycle in_ready = 1 and all other outputs 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the second-generation load/store unit.
package lsu_pkg;

    // Control states. PASS is a one-cycle settle step for ops that never reach the bus.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PASS = 3'd1,
        ST_REQ  = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } lsu_state_e;

    // RISC-V load/store funct3 encodings.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Exception causes reported alongside out_valid.
    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

    // Number of bytes touched by an access; the low two funct3 bits are log2(bytes).
    function automatic logic [3:0] access_bytes(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores, extraction/extension for loads, and
// access legality (misalignment, unsupported width) checks. Purely combinational.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  is_store_i,
    input  logic [2:0]            funct3_i,
    input  logic [2:0]            addr_lo_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W-1:0]     rdata_i,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [DATA_W/8-1:0]   wmask_o,
    output logic [DATA_W-1:0]     load_o,
    output logic                  misalign_o,
    output logic                  illegal_o
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    logic [3:0]        bytes;
    logic [2:0]        amask;
    logic [OFF_W-1:0]  off;
    logic [NB-1:0]     base_mask;
    logic [DATA_W-1:0] shifted;

    // Lane placement, load extension and legality for the presented access.
    always_comb begin
        bytes     = access_bytes(funct3_i);
        amask     = 3'(bytes - 4'd1);
        off       = addr_lo_i[OFF_W-1:0];
        base_mask = '0;
        for (int i = 0; i < NB; i++) begin
            base_mask[i] = (i < int'(bytes));
        end

        misalign_o = (addr_lo_i & amask) != 3'b000;
        if (is_store_i) begin
            illegal_o = funct3_i[2] || ((funct3_i[1:0] == 2'b11) && (DATA_W == 32));
        end else begin
            illegal_o = (funct3_i == 3'b111) ||
                        ((DATA_W == 32) && ((funct3_i == F3_D) || (funct3_i == F3_WU)));
        end

        wdata_o = wdata_i << {off, 3'b000};
        wmask_o = is_store_i ? (base_mask << off) : '0;

        shifted = rdata_i >> {off, 3'b000};
        case (funct3_i)
            F3_B:    load_o = DATA_W'($signed(shifted[7:0]));
            F3_H:    load_o = DATA_W'($signed(shifted[15:0]));
            F3_W:    load_o = DATA_W'($signed(shifted[31:0]));
            F3_BU:   load_o = DATA_W'(shifted[7:0]);
            F3_HU:   load_o = DATA_W'(shifted[15:0]);
            F3_WU:   load_o = DATA_W'(shifted[31:0]);
            F3_D:    load_o = shifted;
            default: load_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ext.sv
// Load/store unit between EXU and WBU: accepts one op, issues at most one bus
// request, waits for the response (or a timeout) and holds the result for WBU.
//
// Handshakes: every valid/ready pair transfers on a clock edge where both are 1.
// A producer holding valid keeps its payload unchanged until that edge; valid
// never depends combinationally on the matching ready.
module lsu_ext
    import lsu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mem_en,
    input  logic                mem_wen,
    input  logic [2:0]          funct3,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   rdata_out,
    output logic                exc_valid,
    output logic [3:0]          exc_code,
    output logic                lsu_reqValid,
    input  logic                lsu_reqReady,
    output logic [ADDR_W-1:0]   lsu_addr,
    output logic [1:0]          lsu_size,
    output logic                lsu_wen,
    output logic [DATA_W-1:0]   lsu_wdata,
    output logic [DATA_W/8-1:0] lsu_wmask,
    input  logic                lsu_respValid,
    input  logic                lsu_respErr,
    input  logic [DATA_W-1:0]   lsu_rdata,
    output lsu_state_e          dbg_state
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    lsu_state_e          state_q, state_d;
    logic [2:0]          f3_q, f3_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                exc_q, exc_d;
    logic [3:0]          code_q, code_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    // In IDLE the checker looks at the incoming op; afterwards at the captured one.
    logic                sel_idle;
    logic                al_store;
    logic [2:0]          al_f3;
    logic [2:0]          al_addr;
    logic [DATA_W-1:0]   al_wdata;
    logic [DATA_W/8-1:0] al_wmask;
    logic [DATA_W-1:0]   al_load;
    logic                al_misalign;
    logic                al_illegal;

    assign sel_idle = (state_q == ST_IDLE);
    assign al_store = sel_idle ? mem_wen : wen_q;
    assign al_f3    = sel_idle ? funct3 : f3_q;
    assign al_addr  = sel_idle ? addr[2:0] : addr_q[2:0];

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .is_store_i (al_store),
        .funct3_i   (al_f3),
        .addr_lo_i  (al_addr),
        .wdata_i    (wdata_q),
        .rdata_i    (lsu_rdata),
        .wdata_o    (al_wdata),
        .wmask_o    (al_wmask),
        .load_o     (al_load),
        .misalign_o (al_misalign),
        .illegal_o  (al_illegal)
    );

    // State, captured op, result and timeout counter registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
            code_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: capture, legality routing, bus wait with timeout, result hold.
    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = wen_q;
        res_d   = res_q;
        exc_d   = exc_q;
        code_d  = code_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    f3_d    = funct3;
                    addr_d  = addr;
                    wdata_d = wdata;
                    wen_d   = mem_wen;
                    res_d   = '0;
                    exc_d   = 1'b0;
                    code_d  = '0;
                    if (!mem_en) begin
                        state_d = ST_PASS;
                    end else if (al_illegal) begin
                        exc_d   = 1'b1;
                        code_d  = mem_wen ? EXC_ST_FAULT : EXC_LD_FAULT;
                        state_d = ST_PASS;
                    end else if (al_misalign) begin
                        exc_d   = 1'b1;
                        code_d  = mem_wen ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
                        state_d = ST_PASS;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_PASS: state_d = ST_DONE;
            ST_REQ: begin
                if (lsu_reqReady) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (TIMEOUT != 0) cnt_d = CW'(cnt_q + 1'b1);
                if (lsu_respValid) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    if (lsu_respErr) begin
                        exc_d  = 1'b1;
                        code_d = wen_q ? EXC_ST_FAULT : EXC_LD_FAULT;
                    end else begin
                        res_d  = wen_q ? '0 : al_load;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    exc_d   = 1'b1;
                    code_d  = wen_q ? EXC_ST_FAULT : EXC_LD_FAULT;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are zero outside the state that owns them.
    always_comb begin
        in_ready     = (state_q == ST_IDLE);
        lsu_reqValid = (state_q == ST_REQ);
        lsu_addr     = lsu_reqValid ? addr_q : '0;
        lsu_size     = lsu_reqValid ? f3_q[1:0] : 2'b00;
        lsu_wen      = lsu_reqValid && wen_q;
        lsu_wdata    = (lsu_reqValid && wen_q) ? al_wdata : '0;
        lsu_wmask    = lsu_reqValid ? al_wmask : '0;
        out_valid    = (state_q == ST_DONE);
        rdata_out    = out_valid ? res_q : '0;
        exc_valid    = out_valid && exc_q;
        exc_code     = out_valid ? code_q : 4'd0;
        dbg_state    = state_q;
    end

endmodule
